// File: rtl/arm_mc_pkg.sv
// arm_mc_pkg: shared states, control encodings and decode helpers for the multicycle ARM controller
package arm_mc_pkg;
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
        S_MEMWR, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
    } state_t;
    localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010, ALU_ORR = 3'b011;
    localparam logic [1:0] IMM_8 = 2'b00, IMM_12 = 2'b01, IMM_24 = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALU = 2'b10;
    localparam logic [1:0] SRCB_RD2 = 2'b00, SRCB_IMM = 2'b01, SRCB_4 = 2'b10;
    localparam logic [1:0] OP_DP = 2'b00, OP_MEM = 2'b01, OP_BR = 2'b10;
    localparam logic [3:0] F_AND = 4'b0000, F_SUB = 4'b0010, F_ADD = 4'b0100, F_CMP = 4'b1010, F_ORR = 4'b1100;
    localparam logic [3:0] COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_AL = 4'b1110, COND_NV = 4'b1111;
    function automatic logic [2:0] dp_alu(input logic [3:0] cmd);
        return cmd == F_ADD ? ALU_ADD : (cmd == F_SUB || cmd == F_CMP) ? ALU_SUB : cmd == F_AND ? ALU_AND : ALU_ORR;
    endfunction
    function automatic logic dp_valid(input logic [3:0] cmd);
        return cmd inside {F_ADD, F_SUB, F_AND, F_ORR, F_CMP};
    endfunction
endpackage

// File: rtl/arm_cond_eval.sv
// arm_cond_eval: evaluates an ARM condition field against the NZCV flags
module arm_cond_eval (
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);
    logic       w_n, w_z, w_c, w_v, w_ge;
    logic [7:0] w_base;
    assign {w_n, w_z, w_c, w_v} = Flags;
    assign w_ge = w_n == w_v;
    // Odd codes invert the even code below them, which also turns AL (1110) into never (1111).
    assign w_base = {1'b1, ~w_z & w_ge, w_ge, w_c & ~w_z, w_v, w_n, w_c, w_z};
    assign CondEx = w_base[Cond[3:1]] ^ Cond[0];
endmodule

// File: rtl/arm_mc_controller.sv
// arm_mc_controller: multicycle FSM control unit with NZCV flags register for the ARMv4-subset core
module arm_mc_controller
    import arm_mc_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [31:12] Instr,
    input  logic [3:0]   ALUFlags,
    output logic         PCWrite,
    output logic         AdrSrc,
    output logic         MemWrite,
    output logic         IRWrite,
    output logic         RegWrite,
    output logic [1:0]   ResultSrc,
    output logic         ALUSrcA,
    output logic [1:0]   ALUSrcB,
    output logic [1:0]   ImmSrc,
    output logic [1:0]   RegSrc,
    output logic [2:0]   ALUControl
);
    state_t     r_state, w_next;
    logic [3:0] r_flags, w_cmd;
    logic [1:0] w_op;
    logic       r_cond_q, w_cond_ex, w_ls, w_imm, w_rd15, w_cmp, w_arith;
    logic       w_fetch, w_decode, w_exec, w_wb, w_unused;
    assign w_op     = Instr[27:26];
    assign w_imm    = Instr[25];
    assign w_cmd    = Instr[24:21];
    assign w_ls     = Instr[20];
    assign w_rd15   = &Instr[15:12];
    assign w_unused = ^Instr[19:16];
    assign w_cmp    = w_cmd == F_CMP;
    assign w_arith  = w_cmd inside {F_ADD, F_SUB, F_CMP};
    assign w_fetch  = r_state == S_FETCH;
    assign w_decode = r_state == S_DECODE;
    assign w_exec   = r_state inside {S_EXECR, S_EXECI};
    assign w_wb     = r_state inside {S_MEMWB, S_ALUWB};

    arm_cond_eval u_cond (
        .Cond   (Instr[31:28]),
        .Flags  (r_flags),
        .CondEx (w_cond_ex)
    );

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:          w_next = S_DECODE;
            S_DECODE:         w_next = w_op == OP_MEM ? S_MEMADR :
                                       w_op == OP_BR  ? S_BRANCH :
                                       (w_op == OP_DP && dp_valid(w_cmd)) ? (w_imm ? S_EXECI : S_EXECR) : S_FETCH;
            S_MEMADR:         w_next = w_ls ? S_MEMRD : S_MEMWR;
            S_MEMRD:          w_next = S_MEMWB;
            S_EXECR, S_EXECI: w_next = w_cmp ? S_FETCH : S_ALUWB;
            default:          w_next = S_FETCH;
        endcase
    end

    // cond_q is captured in DECODE so a flag write in EXECx only affects later instructions.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_FETCH;
            r_flags  <= 4'b0000;
            r_cond_q <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_decode) r_cond_q <= w_cond_ex;
            if (w_exec && r_cond_q && (w_ls || w_cmp)) begin
                r_flags[3:2] <= ALUFlags[3:2];
                if (w_arith) r_flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    assign IRWrite    = ~reset & w_fetch;
    assign PCWrite    = ~reset & (w_fetch | (r_cond_q & ((r_state == S_BRANCH) | (w_wb & w_rd15))));
    assign RegWrite   = ~reset & r_cond_q & w_wb;
    assign MemWrite   = ~reset & r_cond_q & (r_state == S_MEMWR);
    assign AdrSrc     = r_state inside {S_MEMRD, S_MEMWR};
    assign ResultSrc  = (w_fetch || r_state == S_BRANCH) ? RES_ALU : r_state == S_MEMWB ? RES_DATA : RES_ALUOUT;
    assign ALUSrcA    = w_fetch | w_decode;
    assign ALUSrcB    = (w_fetch || w_decode) ? SRCB_4 :
                        (r_state inside {S_MEMADR, S_EXECI, S_BRANCH}) ? SRCB_IMM : SRCB_RD2;
    assign ImmSrc     = w_op;
    assign RegSrc     = {w_op == OP_MEM, w_op == OP_BR};
    assign ALUControl = w_exec ? dp_alu(w_cmd) : ALU_ADD;
endmodule

// File: tb/tb_arm_mc_controller.sv
// tb_arm_mc_controller: directed instruction sequences checked per cycle against a queued expectation scoreboard
module tb_arm_mc_controller;
    logic         clk = 1'b0;
    logic         reset;
    logic [31:12] Instr;
    logic [3:0]   ALUFlags;
    logic         PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
    logic [1:0]   ResultSrc, ALUSrcB, ImmSrc, RegSrc;
    logic [2:0]   ALUControl;
    localparam logic [2:0] A_ADD = 3'b000, A_SUB = 3'b001, A_AND = 3'b010, A_ORR = 3'b011;

    logic [16:0] exp_q[$], msk_q[$];
    string       tag_q[$];
    logic [1:0]  e_imm, e_reg;
    logic [16:0] e_msk;
    int          n_chk = 0, n_pass = 0, n_fail = 0;

    always #5 clk = ~clk;

    arm_mc_controller dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl)
    );

    task automatic push(input string t, input logic pcw, adr, mw, irw, rw, input logic [1:0] res,
                        input logic a, input logic [1:0] b, input logic [2:0] alu);
        exp_q.push_back({pcw, adr, mw, irw, rw, res, a, b, e_imm, e_reg, alu});
        msk_q.push_back(e_msk);
        tag_q.push_back(t);
    endtask

    task automatic start(input logic [19:0] ins, input logic [3:0] fl, input logic [1:0] imm, input logic [1:0] rs);
        Instr = ins;
        ALUFlags = fl;
        e_imm = imm;
        e_reg = rs;
        e_msk = '1;
    endtask

    task automatic fd(input string t);
        push({t, " fetch"}, 1, 0, 0, 1, 0, 2'b10, 1, 2'b10, A_ADD);
        push({t, " decode"}, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, A_ADD);
    endtask

    // Entered at posedge+1 with inputs settled for the cycle; leaves at the next posedge+1.
    task automatic cyc();
        logic [16:0] o, e, m;
        string t;
        #2;
        o = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl};
        e = exp_q.pop_front();
        m = msk_q.pop_front();
        t = tag_q.pop_front();
        n_chk++;
        assert ((o & m) === (e & m)) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", t, o & m, e & m);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        while (exp_q.size() != 0) cyc();
    endtask

    task automatic dp(input string t, input logic [19:0] ins, input logic [3:0] fl, input logic [2:0] alu,
                      input logic wb, pcw, rw);
        start(ins, fl, 2'b00, 2'b00);
        fd(t);
        push({t, " exec"}, 0, 0, 0, 0, 0, 2'b00, 0, {1'b0, ins[13]}, alu);
        if (wb) push({t, " aluwb"}, pcw, 0, 0, 0, rw, 2'b00, 0, 2'b00, A_ADD);
        drain();
    endtask

    task automatic mem(input string t, input logic [19:0] ins, input logic load);
        start(ins, 4'hF, 2'b01, 2'b10);
        fd(t);
        push({t, " memadr"}, 0, 0, 0, 0, 0, 2'b00, 0, 2'b01, A_ADD);
        if (load) begin
            push({t, " memrd"}, 0, 1, 0, 0, 0, 2'b00, 0, 2'b00, A_ADD);
            push({t, " memwb"}, 0, 0, 0, 0, 1, 2'b01, 0, 2'b00, A_ADD);
        end else push({t, " memwr"}, 0, 1, 1, 0, 0, 2'b00, 0, 2'b00, A_ADD);
        drain();
    endtask

    task automatic br(input string t, input logic [19:0] ins, input logic taken);
        start(ins, 4'hF, 2'b10, 2'b01);
        fd(t);
        push({t, " branch"}, taken, 0, 0, 0, 0, 2'b10, 0, 2'b01, A_ADD);
        drain();
    endtask

    initial begin
        reset = 1'b1;
        start(20'h00000, 4'h0, 2'b00, 2'b00);
        @(posedge clk);
        #1;
        push("reset", 0, 0, 0, 0, 0, 2'b10, 1, 2'b10, A_ADD);
        drain();
        reset = 1'b0;
        dp("add_imm", 20'hE2801, 4'hF, A_ADD, 1, 0, 1);
        mem("ldr", 20'hE5902, 1);
        mem("str", 20'hE5801, 0);
        dp("subs_z1", 20'hE2522, 4'b0100, A_SUB, 1, 0, 1);
        br("bne_z1", 20'h1AFFF, 0);
        dp("subs_z0", 20'hE2522, 4'b0000, A_SUB, 1, 0, 1);
        br("bne_z0", 20'h1AFFF, 1);
        dp("addeq", 20'h02801, 4'b0100, A_ADD, 1, 0, 0);
        dp("addseq", 20'h02901, 4'b0100, A_ADD, 1, 0, 0);
        br("bne_after_addseq", 20'h1AFFF, 1);
        dp("cmp", 20'hE3520, 4'b0100, A_SUB, 0, 0, 0);
        br("beq_after_cmp", 20'h0A000, 1);
        dp("orr_reg", 20'hE1812, 4'b0000, A_ORR, 1, 0, 1);
        dp("add_pc", 20'hE280F, 4'b0000, A_ADD, 1, 1, 1);
        dp("add_nv", 20'hF2801, 4'b0000, A_ADD, 1, 0, 0);
        start(20'hE0211, 4'h0, 2'b00, 2'b00);
        fd("eor_undef");
        drain();
        start(20'hEC000, 4'h0, 2'b00, 2'b00);
        e_msk = 17'h1FF87;
        fd("op11");
        drain();
        dp("subs_c1", 20'hE2522, 4'b0010, A_SUB, 1, 0, 1);
        br("bcs_c1", 20'h2A000, 1);
        dp("ands", 20'hE2112, 4'b0000, A_AND, 1, 0, 1);
        br("bcs_after_ands", 20'h2A000, 1);
        dp("cmp_z1", 20'hE3520, 4'b0100, A_SUB, 0, 0, 0);
        // Reset in ALUWB of ADD R15 must suppress both writes and clear Z set by the CMP.
        start(20'hE280F, 4'h0, 2'b00, 2'b00);
        fd("rst_wb");
        push("rst_wb exec", 0, 0, 0, 0, 0, 2'b00, 0, 2'b01, A_ADD);
        drain();
        reset = 1'b1;
        push("rst_wb aluwb", 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, A_ADD);
        drain();
        reset = 1'b0;
        br("bne_after_reset", 20'h1AFFF, 1);
        start(20'hE5902, 4'hF, 2'b01, 2'b10);
        fd("rst_ldr");
        push("rst_ldr memadr", 0, 0, 0, 0, 0, 2'b00, 0, 2'b01, A_ADD);
        drain();
        reset = 1'b1;
        push("rst_ldr memrd", 0, 1, 0, 0, 0, 2'b00, 0, 2'b00, A_ADD);
        drain();
        reset = 1'b0;
        br("beq_after_reset", 20'h0A000, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
